// File: rtl/tag_grant_fsm_if.sv
// tag_grant_fsm_if
//  Bundles the tag-tree root handshake, the transaction source pulses and the
//  grant outputs of tag_grant_fsm.
//  slave  : the grant FSM (consumes tree_tag/tree_rdy/txn_*, drives ack and grant)
//  master : the surroundings (tag tree root + transaction source)
//  tree_tag/tree_rdy/tree_ack : tag tree root handshake
//  txn_start/txn_done         : 1-cycle pulses from the transaction source
//  sel_valid/sel_tag/sel_onehot/busy/txn_cnt : held grant and status
interface tag_grant_fsm_if #(
   parameter int N      = 4,
   parameter int TAG_SZ = (N > 1) ? $clog2(N) : 1,
   parameter int CNT_W  = 16
);
   logic [TAG_SZ-1:0] tree_tag;
   logic              tree_rdy;
   logic              tree_ack;
   logic              txn_start;
   logic              txn_done;
   logic              sel_valid;
   logic [TAG_SZ-1:0] sel_tag;
   logic [N-1:0]      sel_onehot;
   logic              busy;
   logic [CNT_W-1:0]  txn_cnt;

   modport slave (
      input  tree_tag, tree_rdy, txn_start, txn_done,
      output tree_ack, sel_valid, sel_tag, sel_onehot, busy, txn_cnt
   );

   modport master (
      output tree_tag, tree_rdy, txn_start, txn_done,
      input  tree_ack, sel_valid, sel_tag, sel_onehot, busy, txn_cnt
   );
endinterface

// File: rtl/tag_grant_fsm.sv
// tag_grant_fsm
//  Turns the winning tag at the tag-tree root into a grant held for exactly one
//  transaction. The tag is latched on the tree handshake, a one-hot select is
//  driven toward the N cores until the transaction source reports done, then
//  the block re-arms for the next tag.
//  clk  : clock
//  rst  : asynchronous reset, active-high
//  bus  : tag_grant_fsm_if.slave
//         tree_tag/tree_rdy in, tree_ack out (combinational)
//         txn_start/txn_done in (pulses)
//         sel_valid/sel_tag/sel_onehot/busy/txn_cnt out (registered)
module tag_grant_fsm #(
   parameter int N      = 4,
   parameter int TAG_SZ = (N > 1) ? $clog2(N) : 1,
   parameter int CNT_W  = 16
) (
   input  logic           clk,
   input  logic           rst,
   tag_grant_fsm_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HELD = 2'd1,
      BUSY = 2'd2
   } state_t;

   state_t            state;
   logic              sel_valid;
   logic [TAG_SZ-1:0] sel_tag;
   logic [N-1:0]      sel_onehot;
   logic              busy;
   logic [CNT_W-1:0]  txn_cnt;
   logic              ack;

   // Tags outside 0..N-1 decode to all-zero so no core is selected. With a
   // single core the select simply follows the grant.
   function automatic logic [N-1:0] decode(input logic [TAG_SZ-1:0] t);
      logic [N-1:0] oh;
      oh = '0;
      if (N == 1) begin
         oh = '1;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (TAG_SZ'(i) == t) oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

   // Accept only while idle; gated by rst so nothing is consumed during reset.
   assign ack = (state == IDLE) & bus.tree_rdy & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sel_valid  <= 1'b0;
         sel_tag    <= '0;
         sel_onehot <= '0;
         busy       <= 1'b0;
         txn_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ack) begin
                  sel_tag    <= bus.tree_tag;
                  sel_onehot <= decode(bus.tree_tag);
                  sel_valid  <= 1'b1;
                  state      <= HELD;
               end
            end
            HELD: begin
               // A lone txn_done here is stray and ignored.
               if (bus.txn_start) begin
                  if (bus.txn_done) begin
                     state      <= IDLE;
                     sel_valid  <= 1'b0;
                     sel_onehot <= '0;
                     txn_cnt    <= txn_cnt + 1'b1;
                  end else begin
                     state <= BUSY;
                     busy  <= 1'b1;
                  end
               end
            end
            BUSY: begin
               // txn_start while busy is ignored: no nesting.
               if (bus.txn_done) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  sel_valid  <= 1'b0;
                  sel_onehot <= '0;
                  txn_cnt    <= txn_cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               sel_valid  <= 1'b0;
               sel_onehot <= '0;
            end
         endcase
      end
   end

   // sel_tag is left holding the last grant after release.
   assign bus.tree_ack   = ack;
   assign bus.sel_valid  = sel_valid;
   assign bus.sel_tag    = sel_tag;
   assign bus.sel_onehot = sel_onehot;
   assign bus.busy       = busy;
   assign bus.txn_cnt    = txn_cnt;

endmodule
